// File: rtl/neuron_pkg.sv
// Shared fixed-point types, FSM state encoding and saturation helper for the neuron datapath.
// Signed Q16.16 values are carried in the 32-bit fixed_t type.
package neuron_pkg;

  localparam int unsigned FRAC_BITS_DEF = 16;

  typedef logic signed [31:0] fixed_t;

  typedef enum logic [1:0] {
    StAccum,
    StDrain,
    StFinish,
    StHold
  } state_e;

  localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;
  localparam fixed_t FIXED_MIN = 32'sh8000_0000;
  localparam fixed_t FIXED_ONE = 32'sh0001_0000;

  function automatic fixed_t sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF) begin
      return FIXED_MAX;
    end else if (v < 64'shFFFF_FFFF_8000_0000) begin
      return FIXED_MIN;
    end else begin
      return fixed_t'(v[31:0]);
    end
  endfunction

endpackage

// File: rtl/neuron_forward_mac_if.sv
// Stream-in / result-out bundle of the forward-pass neuron.
// slave is the neuron side, master is the producer/consumer side.
interface neuron_forward_mac_if;
  import neuron_pkg::*;

  fixed_t bias;
  logic   in_valid;
  logic   in_ready;
  fixed_t in_data;
  fixed_t in_weight;
  logic   in_last;
  logic   out_valid;
  logic   out_ready;
  fixed_t out_sum;
  fixed_t out_act;
  logic   out_err;

  modport slave (
    input  bias, in_valid, in_data, in_weight, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_act, out_err
  );

  modport master (
    output bias, in_valid, in_data, in_weight, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_act, out_err
  );

endinterface

// File: rtl/neuron_fixed_mul.sv
// Combinational signed fixed-point multiply: full 64-bit product, arithmetic shift by FracBits
// (rounds toward -inf), then saturate to 32 bits.
module neuron_fixed_mul
  import neuron_pkg::*;
#(
  parameter int unsigned FracBits = FRAC_BITS_DEF
) (
  input  fixed_t a_i,
  input  fixed_t b_i,
  output fixed_t p_o
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] prod;
  logic signed [63:0] prod_shr;

  always_comb begin
    a_ext    = a_i;
    b_ext    = b_i;
    prod     = a_ext * b_ext;
    prod_shr = prod >>> FracBits;
    p_o      = sat32(prod_shr);
  end

endmodule

// File: rtl/neuron_forward_mac.sv
// Forward-pass neuron: bias + sum(data*weight) in Q16.16, saturated sum plus activation output.
// Define LEAKY_RELU_EN for a 1/8-slope leaky ReLU instead of plain ReLU.
module neuron_forward_mac
  import neuron_pkg::*;
#(
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
  parameter int unsigned ACC_W     = 48
) (
  input logic                 clk,
  input logic                 rst,
  neuron_forward_mac_if.slave nif
);

  localparam int unsigned CntW = $clog2(N_INPUTS + 1);

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  fixed_t                    prod_q, prod_d;
  logic                      prod_vld_q, prod_vld_d;
  logic                      err_q, err_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  fixed_t                    out_sum_q, out_sum_d;
  fixed_t                    out_act_q, out_act_d;
  logic                      out_err_q, out_err_d;

  fixed_t             mul_p;
  logic               accept;
  logic               beat_last;
  logic signed [63:0] acc_ext;
  fixed_t             sum_sat;
  fixed_t             act_val;

  neuron_fixed_mul #(
    .FracBits(FRAC_BITS)
  ) u_mul (
    .a_i(nif.in_data),
    .b_i(nif.in_weight),
    .p_o(mul_p)
  );

  always_comb begin
    acc_ext = acc_q;
    sum_sat = sat32(acc_ext);
`ifdef LEAKY_RELU_EN
    act_val = sum_sat[31] ? (sum_sat >>> 3) : sum_sat;
`else
    act_val = sum_sat[31] ? '0 : sum_sat;
`endif
  end

  always_comb begin
    accept    = in_ready_q & nif.in_valid;
    beat_last = (cnt_q == CntW'(N_INPUTS - 1));

    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    prod_vld_d  = accept;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_act_d   = out_act_q;
    out_err_d   = out_err_q;

    if (accept) begin
      prod_d = mul_p;
    end
    if (prod_vld_q) begin
      acc_d = acc_q + {{(ACC_W - 32){prod_q[31]}}, prod_q};
    end
    // The pipeline is empty when a new evaluation starts, so loading the bias never drops a product.
    if (accept && (cnt_q == '0)) begin
      acc_d = {{(ACC_W - 32){nif.bias[31]}}, nif.bias};
    end

    unique case (state_q)
      StAccum: begin
        if (accept) begin
          cnt_d = cnt_q + CntW'(1);
          if (nif.in_last || beat_last) begin
            state_d = StDrain;
            cnt_d   = '0;
            err_d   = nif.in_last ? ~beat_last : 1'b1;
          end
        end
      end
      StDrain: begin
        state_d = StFinish;
      end
      StFinish: begin
        out_sum_d   = sum_sat;
        out_act_d   = act_val;
        out_err_d   = err_q;
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (nif.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase

    in_ready_d = (state_d == StAccum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAccum;
      cnt_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_act_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_act_q   <= out_act_d;
      out_err_q   <= out_err_d;
    end
  end

  assign nif.in_ready  = in_ready_q;
  assign nif.out_valid = out_valid_q;
  assign nif.out_sum   = out_sum_q;
  assign nif.out_act   = out_act_q;
  assign nif.out_err   = out_err_q;

endmodule

// File: tb/tb_neuron_forward_mac.sv
// Directed, table-driven bench for neuron_forward_mac; honours LEAKY_RELU_EN for act expectations.
module tb_neuron_forward_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  neuron_forward_mac_if nif ();

  neuron_forward_mac #(
    .N_INPUTS (4),
    .FRAC_BITS(16),
    .ACC_W    (48)
  ) dut (
    .clk(clk),
    .rst(rst),
    .nif(nif)
  );

  typedef struct {
    string            name;
    logic [31:0]      bias;
    logic [3:0][31:0] d;
    logic [3:0][31:0] w;
    int               nbeats;
    int               last_at;
    bit               gap;
    logic [31:0]      sum;
    logic [31:0]      act_relu;
    logic [31:0]      act_leaky;
    logic             err;
  } vec_t;

  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input string nm, input logic [31:0] b,
                              input logic [31:0] d0, d1, d2, d3,
                              input logic [31:0] w0, w1, w2, w3,
                              input int nb, input int la, input bit gp,
                              input logic [31:0] s, ar, al, input logic e);
    vec_t v;
    v.name = nm;
    v.bias = b;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.nbeats = nb; v.last_at = la; v.gap = gp;
    v.sum = s; v.act_relu = ar; v.act_leaky = al; v.err = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive_beat(input vec_t v, input int i);
    nif.in_valid  = 1'b1;
    nif.in_data   = v.d[i];
    nif.in_weight = v.w[i];
    nif.in_last   = (v.last_at == i + 1);
    nif.bias      = (i == 0) ? v.bias : 32'hDEAD_BEEF;
  endtask

  // Entered and left at a negedge; each beat is accepted on the following posedge.
  task automatic send_beats(input vec_t v);
    for (int i = 0; i < v.nbeats; i++) begin
      if (v.gap && i == 1) begin
        nif.in_valid = 1'b0;
        nif.bias     = 32'h1234_5678;
        @(negedge clk);
      end
      drive_beat(v, i);
      check({v.name, " in_ready"}, {31'd0, nif.in_ready}, 32'd1);
      @(negedge clk);
    end
    nif.in_valid = 1'b0;
    nif.in_last  = 1'b0;
  endtask

  task automatic wait_result(input vec_t v);
    int lat = 0;
    check({v.name, " valid_early"}, {31'd0, nif.out_valid}, 32'd0);
    while (!nif.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, lat, 32'd2);
    check({v.name, " sum"}, nif.out_sum, v.sum);
`ifdef LEAKY_RELU_EN
    check({v.name, " act"}, nif.out_act, v.act_leaky);
`else
    check({v.name, " act"}, nif.out_act, v.act_relu);
`endif
    check({v.name, " err"}, {31'd0, nif.out_err}, {31'd0, v.err});
  endtask

  task automatic handshake(input string nm);
    nif.out_ready = 1'b1;
    @(negedge clk);
    nif.out_ready = 1'b0;
    check({nm, " valid_fall"}, {31'd0, nif.out_valid}, 32'd0);
    check({nm, " ready_back"}, {31'd0, nif.in_ready}, 32'd1);
  endtask

  task automatic check_reset(input string nm);
    check({nm, " in_ready"}, {31'd0, nif.in_ready}, 32'd1);
    check({nm, " out_valid"}, {31'd0, nif.out_valid}, 32'd0);
    check({nm, " out_sum"}, nif.out_sum, 32'd0);
    check({nm, " out_act"}, nif.out_act, 32'd0);
    check({nm, " out_err"}, {31'd0, nif.out_err}, 32'd0);
  endtask

  initial begin
    vecs[0] = mk("halves", 32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
                 32'h8000, 32'h8000, 32'h8000, 32'h8000, 4, 4, 1'b0,
                 32'h0005_0000, 32'h0005_0000, 32'h0005_0000, 1'b0);
    vecs[1] = mk("neg_stall", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                 4, 4, 1'b1, 32'hFFFD_0000, 32'h0, 32'hFFFF_A000, 1'b0);
    vecs[2] = mk("sat_pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                 4, 4, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    vecs[3] = mk("sat_neg", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                 4, 4, 1'b0, 32'h8000_0000, 32'h0, 32'hF000_0000, 1'b0);
    vecs[4] = mk("early_last", 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0,
                 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 2, 2, 1'b0,
                 32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 1'b1);
    vecs[5] = mk("no_last", 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 4, 0, 1'b0,
                 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 1'b1);
    vecs[6] = mk("mixed", 32'h0000_8000, 32'h0002_0000, 32'hFFFE_8000, 32'h0000_4000,
                 32'hFFFD_0000, 32'h0001_8000, 32'h0002_0000, 32'hFFFC_0000, 32'h0001_0000,
                 4, 4, 1'b0, 32'hFFFC_8000, 32'h0, 32'hFFFF_9000, 1'b0);
    vecs[7] = mk("floor_one", 32'h0, 32'h0000_0001, 32'h0, 32'h0, 32'h0,
                 32'hFFFF_8000, 32'h0, 32'h0, 32'h0, 1, 1, 1'b0,
                 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b1);

    nif.in_valid  = 1'b0;
    nif.in_last   = 1'b0;
    nif.in_data   = '0;
    nif.in_weight = '0;
    nif.bias      = '0;
    nif.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      send_beats(vecs[k]);
      wait_result(vecs[k]);
      handshake(vecs[k].name);
    end

    // Hold the result with out_ready low, then release with the next evaluation already waiting.
    send_beats(vecs[0]);
    wait_result(vecs[0]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold valid", {31'd0, nif.out_valid}, 32'd1);
      check("hold in_ready", {31'd0, nif.in_ready}, 32'd0);
      check("hold sum", nif.out_sum, vecs[0].sum);
      check("hold act", nif.out_act, vecs[0].act_relu);
      check("hold err", {31'd0, nif.out_err}, 32'd0);
    end
    nif.out_ready = 1'b1;
    drive_beat(vecs[6], 0);
    @(negedge clk);
    nif.out_ready = 1'b0;
    check("b2b valid_fall", {31'd0, nif.out_valid}, 32'd0);
    send_beats(vecs[6]);
    wait_result(vecs[6]);
    handshake("b2b");

    // Reset in the middle of an evaluation, then repeat the first vector.
    drive_beat(vecs[0], 0);
    @(negedge clk);
    drive_beat(vecs[0], 1);
    @(negedge clk);
    rst = 1'b1;
    nif.in_valid = 1'b0;
    nif.in_last  = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_reset");
    send_beats(vecs[0]);
    wait_result(vecs[0]);
    handshake("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
